awgn_snr_sweep_ctrl: RTL and testbench

//  Sequencer for the AWGN channel datapath in SNR-sweep runs. Steps SNR_MIN..SNR_MAX,

---
 rtl/awgn_pkg.sv | 19 +
 rtl/awgn_sigma_lut.sv | 11 +
 rtl/awgn_snr_sweep_ctrl.sv | 93 +++++++++
 tb/tb_awgn_snr_sweep_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/awgn_pkg.sv
// awgn_pkg: sweep controller states and the SNR -> sigma table shared with the awgn datapath.
package awgn_pkg;

    typedef enum logic [2:0] {IDLE, RESEED, SETTLE, RUN, DRAIN, NEXT, DONE} state_t;

    localparam int SNR_POINTS = 10;

    // Q0.8 noise sigma per SNR point in dB
    localparam logic [7:0] SIGMA_LUT [0:SNR_POINTS-1] = '{
        8'd180, 8'd161, 8'd143, 8'd128, 8'd114, 8'd102, 8'd90, 8'd81, 8'd72, 8'd64
    };

    function automatic logic [7:0] sigma_of(input logic [3:0] snr);
        sigma_of = SIGMA_LUT[SNR_POINTS-1];
        for (int i = 0; i < SNR_POINTS; i++)
            if (snr == 4'(i)) sigma_of = SIGMA_LUT[i];
    endfunction

endpackage

// File: rtl/awgn_sigma_lut.sv
// awgn_sigma_lut: combinational SNR (dB) to Q0.8 sigma lookup; out-of-range SNR saturates.
module awgn_sigma_lut
    import awgn_pkg::*;
(
    input  logic [3:0] snr_db,
    output logic [7:0] sigma
);

    always_comb sigma = sigma_of(snr_db);

endmodule

// File: rtl/awgn_snr_sweep_ctrl.sv
// awgn_snr_sweep_ctrl: sequences an SNR sweep over the AWGN datapath, reseeding noise per point
// and streaming SAMPLES_PER_SNR symbols source -> datapath -> sink with valid/ready.
module awgn_snr_sweep_ctrl
    import awgn_pkg::*;
#(
    parameter int SAMPLES_PER_SNR = 32000,
    parameter int SNR_MIN         = 0,
    parameter int SNR_MAX         = 9,
    parameter int SETTLE_CYCLES   = 4,
    parameter int NOISE_LAT       = 1,
    parameter int CNT_W           = 20
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic             sink_ready,
    output logic             sink_valid,
    output logic             noise_read,
    output logic             noise_reseed,
    output logic [7:0]       sigma,
    output logic [3:0]       snr_db,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             done,
    output logic             err_overrun
);

    localparam int WAIT_W = 16;

    state_t              state, state_n;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [NOISE_LAT-1:0] lat_sr;
    logic [3:0]          snr_n;
    logic [7:0]          sigma_n;
    logic                last_xfer, start_ok, overrun;

    awgn_sigma_lut u_sigma_lut (.snr_db(snr_n), .sigma(sigma_n));

    always_comb begin
        src_ready  = (state == RUN) && sink_ready;
        noise_read = src_valid && src_ready;
        last_xfer  = noise_read && (sample_cnt == CNT_W'(SAMPLES_PER_SNR - 1));
        start_ok   = start && (state == IDLE || state == DONE);
        sink_valid = lat_sr[0];
        overrun    = sink_valid && !sink_ready;
        state_n    = state;
        case (state)
            IDLE, DONE: if (start) state_n = RESEED;
            RESEED:     state_n = SETTLE;
            SETTLE:     if (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1)) state_n = RUN;
            RUN:        if (last_xfer) state_n = DRAIN;
            DRAIN:      if (wait_cnt == WAIT_W'(NOISE_LAT - 1)) state_n = NEXT;
            NEXT:       state_n = (snr_db == 4'(SNR_MAX)) ? DONE : RESEED;
            default:    state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
        snr_n = abort ? snr_db
              : start_ok ? 4'(SNR_MIN)
              : (state == NEXT && snr_db != 4'(SNR_MAX)) ? snr_db + 4'd1
              : snr_db;
    end

    // wait_cnt restarts on every state change, so SETTLE and DRAIN both time from zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            lat_sr       <= '0;
            snr_db       <= 4'(SNR_MIN);
            sigma        <= sigma_of(4'(SNR_MIN));
            sample_cnt   <= '0;
            noise_reseed <= 1'b0;
            done         <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            state        <= state_n;
            wait_cnt     <= (state_n != state) ? '0 : wait_cnt + WAIT_W'(1);
            lat_sr       <= abort ? '0 : (lat_sr >> 1) | (NOISE_LAT'(noise_read) << (NOISE_LAT - 1));
            snr_db       <= snr_n;
            sigma        <= sigma_n;
            sample_cnt   <= (abort || state_n == RESEED) ? '0 : sample_cnt + CNT_W'(noise_read);
            noise_reseed <= abort || state_n == RESEED;
            done         <= state_n == DONE;
            err_overrun  <= abort ? err_overrun
                          : (start_ok && state == IDLE) ? 1'b0
                          : err_overrun || overrun;
        end
    end

endmodule

// File: tb/tb_awgn_snr_sweep_ctrl.sv
// tb_awgn_snr_sweep_ctrl: directed and randomized sweeps compared every cycle against a
// transaction-level model of the sweep, plus hand-computed pins on key cycles.
module tb_awgn_snr_sweep_ctrl;

    localparam int S = 8, MIN = 0, MAX = 2, SET = 4, LAT = 1, CW = 20;
    localparam int M_IDLE = 0, M_RESEED = 1, M_SETTLE = 2, M_RUN = 3, M_DRAIN = 4, M_NEXT = 5, M_DONE = 6;

    logic clk = 0, reset = 0, start = 0, abort = 0, src_valid = 0, sink_ready = 0;
    logic src_ready, sink_valid, noise_read, noise_reseed, done, err_overrun;
    logic [7:0] sigma;
    logic [3:0] snr_db;
    logic [CW-1:0] sample_cnt;

    always #5 clk = ~clk;

    awgn_snr_sweep_ctrl #(.SAMPLES_PER_SNR(S), .SNR_MIN(MIN), .SNR_MAX(MAX),
                          .SETTLE_CYCLES(SET), .NOISE_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_valid(src_valid), .src_ready(src_ready), .sink_ready(sink_ready),
        .sink_valid(sink_valid), .noise_read(noise_read), .noise_reseed(noise_reseed),
        .sigma(sigma), .snr_db(snr_db), .sample_cnt(sample_cnt), .done(done),
        .err_overrun(err_overrun)
    );

    int vectors = 0, miscompares = 0;
    int sig_tab [10] = '{180, 161, 143, 128, 114, 102, 90, 81, 72, 64};
    int m_mode, m_timer, m_snr, m_cnt;
    bit m_done, m_err, m_reseed, armed;
    bit pipe [$];
    int n_sv = 0, n_res = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_snr = MIN; m_cnt = 0; m_done = 0; m_err = 0; m_reseed = 0; m_timer = 0;
        pipe = {};
        repeat (LAT) pipe.push_back(1'b0);
    endtask

    task automatic begin_point(input int s);
        m_snr = s; m_cnt = 0; m_mode = M_RESEED; m_reseed = 1; m_done = 0;
    endtask

    task automatic model_update();
        bit rd, ov;
        rd = (m_mode == M_RUN) && sink_ready && src_valid;
        ov = pipe[0] && !sink_ready;
        if (!reset) begin
            model_reset();
            return;
        end
        if (abort) begin
            m_mode = M_IDLE; m_cnt = 0; m_done = 0; m_reseed = 1;
            foreach (pipe[i]) pipe[i] = 1'b0;
            return;
        end
        pipe.push_back(rd);
        void'(pipe.pop_front());
        m_err = m_err | ov;
        m_reseed = 0;
        case (m_mode)
            M_IDLE:   if (start) begin m_err = 0; begin_point(MIN); end
            M_RESEED: begin m_mode = M_SETTLE; m_timer = SET; end
            M_SETTLE: begin m_timer -= 1; if (m_timer == 0) m_mode = M_RUN; end
            M_RUN:    if (rd) begin
                          m_cnt++;
                          if (m_cnt == S) begin m_mode = M_DRAIN; m_timer = LAT; end
                      end
            M_DRAIN:  begin m_timer -= 1; if (m_timer == 0) m_mode = M_NEXT; end
            M_NEXT:   if (m_snr == MAX) begin m_mode = M_DONE; m_done = 1; end
                      else begin_point(m_snr + 1);
            default:  if (start) begin_point(MIN);
        endcase
    endtask

    task automatic compare_all();
        bit rdy;
        rdy = (m_mode == M_RUN) && sink_ready;
        chk("src_ready", src_ready, rdy);
        chk("noise_read", noise_read, rdy && src_valid);
        chk("sink_valid", sink_valid, pipe[0]);
        chk("noise_reseed", noise_reseed, m_reseed);
        chk("snr_db", snr_db, m_snr);
        chk("sigma", sigma, sig_tab[m_snr]);
        chk("sample_cnt", sample_cnt, m_cnt);
        chk("done", done, m_done);
        chk("err_overrun", err_overrun, m_err);
    endtask

    // inputs set by the caller are compared at negedge, sampled at posedge, then settle
    task automatic step();
        @(negedge clk);
        if (armed) compare_all();
        n_sv += int'(sink_valid === 1'b1);
        n_res += int'(noise_reseed === 1'b1);
        @(posedge clk);
        model_update();
        armed = 1;
        #1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) return;
            step();
        end
        chk("done_timeout", done, 1);
    endtask

    initial begin
        int base_sv, base_res;
        bit found;
        model_reset();
        armed = 0;
        repeat (3) step();
        chk("rst_src_ready", src_ready, 0);
        chk("rst_sink_valid", sink_valid, 0);
        chk("rst_noise_read", noise_read, 0);
        chk("rst_noise_reseed", noise_reseed, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_overrun, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_snr", snr_db, 0);
        chk("rst_sigma", sigma, 180);

        // full sweep with everything ready; a start mid-sweep must be ignored
        reset = 1; src_valid = 1; sink_ready = 1;
        step();
        base_sv = n_sv; base_res = n_res;
        start = 1; step(); start = 0;
        chk("reseed_after_start", noise_reseed, 1);
        repeat (20) step();
        start = 1; step(); start = 0;
        wait_done(200);
        chk("sweep_done", done, 1);
        chk("sink_valid_total", n_sv - base_sv, 24);
        chk("reseed_total", n_res - base_res, 3);
        chk("final_snr", snr_db, 2);
        chk("final_sigma", sigma, 143);
        chk("final_cnt", sample_cnt, 8);

        // start from DONE, then randomized flow control
        start = 1; step(); start = 0;
        chk("done_drops", done, 0);
        chk("restart_snr", snr_db, 0);
        for (int i = 0; i < 3000 && done !== 1'b1; i++) begin
            src_valid = 1'($urandom % 2);
            sink_ready = 1'(($urandom % 4) != 0);
            start = 1'(($urandom % 16) == 0);
            step();
        end
        start = 0;
        chk("random_sweep_done", done, 1);

        // overrun: sink drops the cycle after the last read of a point
        abort = 1; step(); abort = 0;
        chk("abort_reseed", noise_reseed, 1);
        chk("abort_done", done, 0);
        src_valid = 1; sink_ready = 1;
        start = 1; step(); start = 0;
        chk("err_cleared_by_start", err_overrun, 0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (noise_read === 1'b1 && sample_cnt == 7 && snr_db == 0) found = 1;
            else step();
        end
        chk("found_last_read", found, 1);
        step();
        sink_ready = 0; step(); sink_ready = 1;
        chk("err_set", err_overrun, 1);
        wait_done(200);
        chk("err_sticky_done", err_overrun, 1);

        // abort at sample_cnt 5 of snr 1, then restart
        start = 1; step(); start = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (snr_db == 1 && sample_cnt == 5) found = 1;
            else step();
        end
        chk("found_cnt5", found, 1);
        abort = 1; step(); abort = 0;
        chk("abort_cnt", sample_cnt, 0);
        chk("abort_pulse", noise_reseed, 1);
        step();
        chk("abort_pulse_end", noise_reseed, 0);
        start = 1; step(); start = 0;
        chk("restart_after_abort_snr", snr_db, 0);
        chk("restart_after_abort_sigma", sigma, 180);
        wait_done(200);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
